timer_wb: RTL and testbench

Wishbone classic-cycle slave timer peripheral for the MIPS system. It sits on the intercon as a responder beside the RAM and GPIO slaves, and gives CPU software a programmable down-counter. The counter has a prescaler, optional auto-reload, and a sticky expiry flag with a level interrupt output.

---
 rtl/timer_wb_if.sv | 22 ++
 rtl/timer_wb.sv | 147 ++++++++++++++
 tb/tb_timer_wb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_wb_if.sv
// Wishbone classic-cycle bus bundle for the timer peripheral.
// Signal directions are named from the slave's point of view.
interface timer_wb_if;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [31:0] adr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;

    modport master (
        output dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  dat_i, adr_i, we_i, sel_i, cyc_i, stb_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/timer_wb.sv
// Wishbone slave down-counter timer with prescaler,
// optional auto-reload and a sticky expiry interrupt.
module timer_wb #(
    parameter int PRESC_W = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    timer_wb_if.slave bus,
    output logic      irq_o
);

    logic               en_q, en_d;
    logic               auto_q, auto_d;
    logic               ie_q, ie_d;
    logic               exp_q, exp_d;
    logic               ack_q, ack_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        dat_q, dat_d;

    logic        acc;
    logic        wr;
    logic [1:0]  adr;
    logic [31:0] wmask;
    logic [31:0] ctrl_w;
    logic [31:0] rdata;
    logic        tick;
    logic        expire;
    logic        halt;
    logic        unused_adr;

    assign unused_adr = ^{bus.adr_i[31:4], bus.adr_i[1:0]};

    // Bus decode, prescaler, counter update and write merging
    always_comb begin
        acc   = bus.cyc_i & bus.stb_i & ~ack_q;
        wr    = acc & bus.we_i;
        adr   = bus.adr_i[3:2];
        wmask = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}},
                 {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};

        ctrl_w                = '0;
        ctrl_w[0]             = en_q;
        ctrl_w[1]             = auto_q;
        ctrl_w[2]             = ie_q;
        ctrl_w[16 +: PRESC_W] = presc_q;

        unique case (adr)
            2'd0:    rdata = ctrl_w;
            2'd1:    rdata = load_q;
            2'd2:    rdata = count_q;
            default: rdata = {31'd0, exp_q};
        endcase

        tick   = en_q & (pcnt_q == presc_q);
        expire = tick & (count_q <= 32'd1);
        // software stopping the timer cancels this edge's count step
        halt   = wr & (adr == 2'd0) & bus.sel_i[0] & ~bus.dat_i[0];

        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        pcnt_d = '0;
        if (en_q && !tick) begin
            pcnt_d = pcnt_q + PRESC_W'(1);
        end

        if (tick && !halt) begin
            if (expire) begin
                count_d = auto_q ? load_q : 32'd0;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (expire) begin
            exp_d = 1'b1;
            if (!auto_q) begin
                en_d = 1'b0;
            end
        end

        if (wr) begin
            unique case (adr)
                2'd0: begin
                    if (bus.sel_i[0]) begin
                        en_d   = bus.dat_i[0];
                        auto_d = bus.dat_i[1];
                        ie_d   = bus.dat_i[2];
                    end
                    presc_d = (presc_q & ~wmask[16 +: PRESC_W])
                            | (bus.dat_i[16 +: PRESC_W]
                               & wmask[16 +: PRESC_W]);
                end
                2'd1: load_d = (load_q & ~wmask) | (bus.dat_i & wmask);
                2'd2: count_d = (count_q & ~wmask) | (bus.dat_i & wmask);
                default: begin
                    if (bus.sel_i[0] && bus.dat_i[0] && !expire) begin
                        exp_d = 1'b0;
                    end
                end
            endcase
        end

        ack_d = acc;
        dat_d = (acc && !bus.we_i) ? rdata : dat_q;
    end

    // Register state; everything clears on reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            ack_q   <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            dat_q   <= '0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            exp_q   <= exp_d;
            ack_q   <= ack_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            load_q  <= load_d;
            count_q <= count_d;
            dat_q   <= dat_d;
        end
    end

    assign bus.ack_o = ack_q;
    assign bus.dat_o = dat_q;
    assign irq_o     = exp_q & ie_q;

endmodule

// File: tb/tb_timer_wb.sv
// Bench for timer_wb: directed scenarios with fixed expectations
// plus random bus traffic against a behavioural model.
module tb_timer_wb;

    logic clk;
    logic rst_n;
    logic irq;
    int   n_chk;
    int   n_pass;

    timer_wb_if bus ();

    timer_wb dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus),
        .irq_o (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit          m_en, m_auto, m_ie, m_exp, m_ack;
    logic [15:0] m_presc, m_pcnt;
    logic [31:0] m_load, m_count, m_dat;

    function automatic logic [31:0] img(input int a);
        case (a)
            0:       return {m_presc, 13'd0, m_ie, m_auto, m_en};
            1:       return m_load;
            2:       return m_count;
            default: return {31'd0, m_exp};
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // Model advances one edge: timer rules first, bus write wins after
    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] w;
        logic [31:0] c;
        bit          acc;
        bit          tick;
        bit          expd;
        int          a;
        if (!rst_n) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ack = 0;
            m_presc = 0; m_pcnt = 0;
            m_load = 0; m_count = 0; m_dat = 0;
        end else begin
            acc  = bus.cyc_i && bus.stb_i && !m_ack;
            a    = int'(bus.adr_i[3:2]);
            tick = m_en && (m_pcnt == m_presc);
            expd = tick && (m_count <= 1);
            c    = m_count;
            w    = merge(img(a), bus.dat_i, bus.sel_i);
            if (acc && !bus.we_i) m_dat = img(a);
            m_pcnt = (m_en && !tick) ? m_pcnt + 16'd1 : 16'd0;
            if (tick) begin
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else begin
                    m_count = m_auto ? m_load : 32'd0;
                    if (!m_auto) m_en = 0;
                    m_exp = 1;
                end
            end
            if (acc && bus.we_i) begin
                case (a)
                    0: begin
                        if (bus.sel_i[0]) begin
                            m_en   = w[0];
                            m_auto = w[1];
                            m_ie   = w[2];
                            if (!w[0]) m_count = c;
                        end
                        m_presc = w[31:16];
                    end
                    1: m_load = w;
                    2: m_count = w;
                    default: begin
                        if (bus.sel_i[0] && bus.dat_i[0] && !expd) m_exp = 0;
                    end
                endcase
            end
            m_ack = acc;
        end
    end

    // Continuous comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_ack", {31'd0, bus.ack_o}, {31'd0, m_ack});
            chk("mon_irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
            chk("mon_dat", bus.dat_o, m_dat);
        end
    end

    task automatic idle_bus();
        bus.cyc_i = 0;
        bus.stb_i = 0;
        bus.we_i  = 0;
        bus.sel_i = 0;
        bus.dat_i = 0;
        bus.adr_i = 0;
    endtask

    task automatic drive(input bit we, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = $urandom;
        r[3:2] = a;
        bus.adr_i = r;
        bus.cyc_i = 1;
        bus.stb_i = 1;
        bus.we_i  = we;
        bus.dat_i = d;
        bus.sel_i = s;
    endtask

    task automatic wb(input bit we, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q);
        drive(we, a, d, s);
        @(posedge clk); #1;
        chk("ack_hi", {31'd0, bus.ack_o}, 32'd1);
        q = bus.dat_o;
        idle_bus();
        @(posedge clk); #1;
        chk("ack_lo", {31'd0, bus.ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] q;
        wb(1'b1, a, d, s, q);
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [31:0] exp);
        logic [31:0] q;
        wb(1'b0, a, 32'd0, 4'hF, q);
        chk(tag, q, exp);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_LOAD = 2'd1;
    localparam logic [1:0] A_CNT  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 0;
        idle_bus();
        edges(3);
        rst_n = 1;
        edges(1);

        // Reset during an active write
        wr(A_LOAD, 32'h1234_5678, 4'hF);
        rd("pre_load", A_LOAD, 32'h1234_5678);
        wr(A_CNT, 32'd1, 4'hF);
        wr(A_CTRL, 32'h0000_0005, 4'hF);
        chk("pre_irq", {31'd0, irq}, 32'd1);
        drive(1'b1, A_CTRL, 32'h0000_0007, 4'hF);
        @(posedge clk); #1;
        chk("pre_ack", {31'd0, bus.ack_o}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        chk("rst_dat", bus.dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1;
        edges(1);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_load", A_LOAD, 32'd0);
        rd("rst_cnt", A_CNT, 32'd0);
        rd("rst_stat", A_STAT, 32'd0);

        // Byte-select write
        wr(A_LOAD, 32'hAABB_CCDD, 4'b0011);
        rd("sel_load", A_LOAD, 32'h0000_CCDD);
        rd("load_no_cnt", A_CNT, 32'd0);

        // One-shot, PRESC=1
        wr(A_CNT, 32'd3, 4'hF);
        wr(A_CTRL, 32'h0001_0005, 4'hF);
        edges(1);
        rd("os_cnt2", A_CNT, 32'd2);
        chk("os_irq0", {31'd0, irq}, 32'd0);
        rd("os_cnt1", A_CNT, 32'd1);
        rd("os_cnt0", A_CNT, 32'd0);
        chk("os_irq1", {31'd0, irq}, 32'd1);
        rd("os_ctrl", A_CTRL, 32'h0001_0004);
        rd("os_hold", A_CNT, 32'd0);
        rd("os_exp", A_STAT, 32'd1);

        // W1C needs sel_i[0]
        wr(A_STAT, 32'd1, 4'b1110);
        rd("w1c_nosel", A_STAT, 32'd1);
        wr(A_STAT, 32'd1, 4'b0001);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        rd("w1c_exp", A_STAT, 32'd0);

        // Auto-reload, PRESC=0, period 4
        wr(A_LOAD, 32'd4, 4'hF);
        wr(A_CNT, 32'd4, 4'hF);
        wr(A_CTRL, 32'h0000_0007, 4'hF);
        rd("ar_cnt3", A_CNT, 32'd3);
        chk("ar_irq0", {31'd0, irq}, 32'd0);
        edges(1);
        chk("ar_irq1", {31'd0, irq}, 32'd1);
        rd("ar_reload", A_CNT, 32'd4);
        drive(1'b1, A_STAT, 32'd1, 4'b0001);
        @(posedge clk); #1;
        chk("clr_irq", {31'd0, irq}, 32'd0);
        idle_bus();
        @(posedge clk); #1;
        chk("ar_period", {31'd0, irq}, 32'd1);
        edges(3);
        wr(A_STAT, 32'd1, 4'b0001);
        chk("col_irq", {31'd0, irq}, 32'd1);
        rd("col_exp", A_STAT, 32'd1);

        // COUNT write on a tick edge, PRESC=3
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_CNT, 32'd50, 4'hF);
        wr(A_CTRL, 32'h0003_0001, 4'hF);
        edges(2);
        wr(A_CNT, 32'd100, 4'hF);
        rd("cw_100a", A_CNT, 32'd100);
        rd("cw_100b", A_CNT, 32'd100);
        rd("cw_99", A_CNT, 32'd99);

        // Random traffic, checked by the model monitor
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] r;
            int          a;
            a = $urandom_range(0, 3);
            r = $urandom;
            r[3:2] = 2'(a);
            bus.adr_i = r;
            bus.cyc_i = ($urandom_range(0, 9) < 7);
            bus.stb_i = bus.cyc_i && ($urandom_range(0, 9) < 8);
            bus.we_i  = 1'($urandom_range(0, 1));
            bus.sel_i = 4'($urandom);
            case (a)
                0:       bus.dat_i = $urandom & 32'h0003_0007;
                1, 2:    bus.dat_i = $urandom_range(0, 12);
                default: bus.dat_i = $urandom;
            endcase
            @(posedge clk); #1;
        end
        idle_bus();
        edges(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
